// File: rtl/beat_detector_multi.sv
// Multi-channel beat detector: grades absolute sample-to-sample deltas and emits beat pulses with hold-off.
// Optional beat counter output enabled by defining BEAT_DETECTOR_COUNT_EN.
module beat_detector_multi #(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 16,
  parameter int LVL1        = 3000,
  parameter int LVL2        = 4500,
  parameter int LVL3        = 6500,
  parameter int HOLDOFF_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  output logic                     beat_en,
  output logic [1:0]               beat_intensity,
  output logic [NUM_CH-1:0]        beat_ch,
  output logic                     holdoff
`ifdef BEAT_DETECTOR_COUNT_EN
  ,
  output logic [15:0]              beat_count
`endif
);

  localparam int CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [DATA_W:0] THR1 = (DATA_W+1)'(LVL1);
  localparam logic [DATA_W:0] THR2 = (DATA_W+1)'(LVL2);
  localparam logic [DATA_W:0] THR3 = (DATA_W+1)'(LVL3);

  typedef enum logic [1:0] {
    S_PRIME,
    S_ARMED,
    S_HOLDOFF
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    hold_cnt;

  logic [DATA_W-1:0]   prev_q  [NUM_CH];
  logic [DATA_W:0]     delta_q [NUM_CH];
  logic                d_valid;

  logic [DATA_W:0]     cur_x   [NUM_CH];
  logic [DATA_W:0]     prev_x  [NUM_CH];
  logic [DATA_W:0]     diff    [NUM_CH];
  logic [DATA_W:0]     mag     [NUM_CH];
  logic [1:0]          lvl     [NUM_CH];
  logic [1:0]          lvl_max;
  logic [NUM_CH-1:0]   lvl_mask;
  logic                beat_fire;

  // Sign-extend by one bit so the full-scale swing cannot wrap before taking the magnitude.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cur_x[i]  = {sample_data[i*DATA_W+DATA_W-1], sample_data[i*DATA_W +: DATA_W]};
      prev_x[i] = {prev_q[i][DATA_W-1], prev_q[i]};
      diff[i]   = cur_x[i] - prev_x[i];
      mag[i]    = diff[i][DATA_W] ? (~diff[i] + 1'b1) : diff[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i]  <= '0;
        delta_q[i] <= '0;
      end
      d_valid <= 1'b0;
    end else begin
      if (sample_valid) begin
        for (int i = 0; i < NUM_CH; i++) begin
          prev_q[i]  <= sample_data[i*DATA_W +: DATA_W];
          delta_q[i] <= mag[i];
        end
      end
      d_valid <= sample_valid && (state != S_PRIME);
    end
  end

  // Strict comparisons: a delta equal to a threshold lands in the lower level.
  always_comb begin
    lvl_max  = 2'd0;
    lvl_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (delta_q[i] > THR3)      lvl[i] = 2'd3;
      else if (delta_q[i] > THR2) lvl[i] = 2'd2;
      else if (delta_q[i] > THR1) lvl[i] = 2'd1;
      else                        lvl[i] = 2'd0;
      lvl_mask[i] = (lvl[i] != 2'd0);
      if (lvl[i] > lvl_max) lvl_max = lvl[i];
    end
  end

  assign beat_fire = d_valid && (lvl_max != 2'd0) && (state == S_ARMED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_PRIME;
      hold_cnt       <= '0;
      holdoff        <= 1'b0;
      beat_en        <= 1'b0;
      beat_intensity <= 2'd0;
      beat_ch        <= '0;
`ifdef BEAT_DETECTOR_COUNT_EN
      beat_count     <= 16'd0;
`endif
    end else begin
      beat_en <= beat_fire;
      if (beat_fire) begin
        beat_intensity <= lvl_max;
        beat_ch        <= lvl_mask;
`ifdef BEAT_DETECTOR_COUNT_EN
        if (beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
`endif
      end
      case (state)
        S_PRIME: begin
          if (sample_valid) state <= S_ARMED;
        end
        S_ARMED: begin
          if (beat_fire && (HOLDOFF_CYC > 0)) begin
            state    <= S_HOLDOFF;
            hold_cnt <= CNT_W'(HOLDOFF_CYC - 1);
            holdoff  <= 1'b1;
          end
        end
        S_HOLDOFF: begin
          // Deltas evaluated while here, including the terminal-count cycle, are dropped.
          if (hold_cnt == '0) begin
            state   <= S_ARMED;
            holdoff <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= S_PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_detector_multi.sv
// Randomized scoreboard bench for beat_detector_multi against a delta/threshold reference model.
module tb_beat_detector_multi;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int HOLD   = 8;

  typedef struct {
    int         at_edge;
    logic [1:0] lvl;
    logic [2:0] mask;
  } exp_t;

  logic                     clk;
  logic                     rst;
  logic                     sample_valid;
  logic [NUM_CH*DATA_W-1:0] sample_data;
  logic                     beat_en;
  logic [1:0]               beat_intensity;
  logic [NUM_CH-1:0]        beat_ch;
  logic                     holdoff;

  exp_t exp_q[$];
  int   edge_n;
  int   n_checks;
  int   n_fail;

  int   prev_m [NUM_CH];
  bit   primed_m;
  int   last_beat_m;

  logic [1:0] held_lvl;
  logic [2:0] held_mask;
  int         mon_last;

  beat_detector_multi #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W),
    .LVL1(3000), .LVL2(4500), .LVL3(6500),
    .HOLDOFF_CYC(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .beat_en(beat_en),
    .beat_intensity(beat_intensity),
    .beat_ch(beat_ch),
    .holdoff(holdoff)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edge_n = 0;
    forever begin
      @(posedge clk);
      edge_n++;
    end
  end

  function automatic int grade(input int d);
    if (d > 6500) return 3;
    if (d > 4500) return 2;
    if (d > 3000) return 1;
    return 0;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // A sample driven after edge k is accepted at k+1 and its beat is decided at k+2.
  task automatic apply_stimulus(input bit v, input int c0, input int c1, input int c2);
    int   cur [NUM_CH];
    int   d;
    int   lv;
    int   lmax;
    logic [2:0] m;
    exp_t e;
    @(posedge clk);
    #1;
    sample_valid = v;
    sample_data  = {16'(c2), 16'(c1), 16'(c0)};
    if (v) begin
      cur[0] = c0; cur[1] = c1; cur[2] = c2;
      lmax = 0;
      m = 3'b000;
      if (primed_m) begin
        for (int i = 0; i < NUM_CH; i++) begin
          d  = cur[i] - prev_m[i];
          d  = (d < 0) ? -d : d;
          lv = grade(d);
          if (lv > 0) m[i] = 1'b1;
          if (lv > lmax) lmax = lv;
        end
        if (lmax > 0 && (edge_n + 2) > last_beat_m + HOLD) begin
          e.at_edge = edge_n + 2;
          e.lvl     = 2'(lmax);
          e.mask    = m;
          exp_q.push_back(e);
          last_beat_m = edge_n + 2;
        end
      end
      primed_m = 1'b1;
      for (int i = 0; i < NUM_CH; i++) prev_m[i] = cur[i];
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample_valid = 1'b0;
    exp_q.delete();
    primed_m = 1'b0;
    last_beat_m = -1000;
    for (int i = 0; i < NUM_CH; i++) prev_m[i] = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) apply_stimulus(1'b0, 0, 0, 0);
  endtask

  // Monitor: pops the expected beat due at this edge and tracks held outputs and hold-off window.
  initial begin
    exp_t e;
    bit   hit;
    bit   exp_hold;
    held_lvl  = 2'd0;
    held_mask = 3'd0;
    mon_last  = -1000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_output("rst_beat_en", int'(beat_en), 0);
        check_output("rst_intensity", int'(beat_intensity), 0);
        check_output("rst_beat_ch", int'(beat_ch), 0);
        check_output("rst_holdoff", int'(holdoff), 0);
        held_lvl  = 2'd0;
        held_mask = 3'd0;
        mon_last  = -1000;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].at_edge < edge_n) begin
          e = exp_q.pop_front();
          check_output("missed_beat", 0, 1);
        end
        hit = (exp_q.size() > 0) && (exp_q[0].at_edge == edge_n);
        if (hit) begin
          e = exp_q.pop_front();
          check_output("beat_en", int'(beat_en), 1);
          held_lvl  = e.lvl;
          held_mask = e.mask;
          mon_last  = edge_n;
        end else begin
          check_output("beat_en", int'(beat_en), 0);
        end
        check_output("beat_intensity", int'(beat_intensity), int'(held_lvl));
        check_output("beat_ch", int'(beat_ch), int'(held_mask));
        exp_hold = (edge_n >= mon_last) && (edge_n < mon_last + HOLD);
        check_output("holdoff", int'(holdoff), int'(exp_hold));
      end
    end
  end

  initial begin
    int a [NUM_CH];
    bit v;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_data = '0;
    primed_m = 1'b0;
    last_beat_m = -1000;
    for (int i = 0; i < NUM_CH; i++) prev_m[i] = 0;
    #2;
    rst = 1'b0;
    do_reset(2);

    $display("[TB] directed: prime then level-3 beat");
    apply_stimulus(1'b1, 0, 0, 0);
    apply_stimulus(1'b1, 7000, 0, 0);
    idle(12);

    $display("[TB] directed: signed delta on threshold, hold-off suppression");
    apply_stimulus(1'b1, 7000, -2000, 0);
    apply_stimulus(1'b1, 7000, 2500, 0);
    apply_stimulus(1'b1, 7000, 7001, 0);
    idle(12);

    $display("[TB] directed: max across channels");
    apply_stimulus(1'b1, 10500, 12001, 100);
    idle(12);

    $display("[TB] directed: qualifying deltas every cycle through hold-off");
    for (int n = 0; n < 24; n++) apply_stimulus(1'b1, (n % 2 == 0) ? 3000 : 10500, 12001, 100);
    idle(12);

    $display("[TB] directed: reset mid hold-off");
    apply_stimulus(1'b1, 0, 12001, 100);
    idle(3);
    do_reset(2);
    apply_stimulus(1'b1, 7000, 0, 0);
    apply_stimulus(1'b1, 0, 0, 0);
    idle(12);

    $display("[TB] directed: idle gaps between valid samples");
    apply_stimulus(1'b1, 0, 0, 0);
    apply_stimulus(1'b0, 30000, 30000, 30000);
    apply_stimulus(1'b0, -30000, 30000, -30000);
    apply_stimulus(1'b1, 6600, 0, 0);
    idle(12);

    $display("[TB] directed: full-scale swing");
    apply_stimulus(1'b1, -32768, -32768, -32768);
    idle(12);
    apply_stimulus(1'b1, 32767, 32767, 32767);
    idle(12);

    $display("[TB] randomized phase");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        v = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < NUM_CH; i++) begin
          if ($urandom_range(0, 49) == 0) begin
            a[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
          end else begin
            a[i] = prev_m[i] + int'($urandom_range(0, 16000)) - 8000;
            if (a[i] > 32767) a[i] = 32767;
            if (a[i] < -32768) a[i] = -32768;
          end
        end
        apply_stimulus(v, a[0], a[1], a[2]);
      end
    end
    idle(12);

    check_output("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/beat_detector_multi.md
Name: beat_detector_multi

Overview:
Parametrised multi-channel accelerometer beat detector, next generation of the fixed 3-axis beat generator.
- Takes a valid-qualified vector of signed samples, forms per-channel absolute sample-to-sample deltas and grades them against three thresholds.
- Emits a single-cycle beat pulse with intensity and a channel mask, followed by a programmable hold-off (refractory) period.
- Sits between the accelerometer interface and the beat/sound consumers.

Parameters:
- NUM_CH, 3: number of channels (axes); must be >= 1.
- DATA_W, 16: per-channel sample width, two's complement signed.
- LVL1, 3000: level-1 threshold; delta > LVL1 -> intensity 1.
- LVL2, 4500: level-2 threshold; delta > LVL2 -> intensity 2.
- LVL3, 6500: level-3 threshold; delta > LVL3 -> intensity 3.
- HOLDOFF_CYC, 1000: clock cycles of beat suppression after each beat; 0 disables hold-off.
- Constraint: 0 <= LVL1 < LVL2 < LVL3 < 2^DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W], signed.
- beat_en  out  1  one-cycle beat pulse.
- beat_intensity  out  2  graded intensity of the last beat (1..3); held between beats.
- beat_ch  out  NUM_CH  mask of channels whose delta exceeded LVL1 at the last beat; held between beats.
- holdoff  out  1  high while beats are suppressed.

Behaviour:
- Reset (rst=0, async): beat_en=0, beat_intensity=0, beat_ch=0, holdoff=0, all prev-sample registers=0, pipeline valids=0, FSM=PRIME, hold-off counter=0.
- Sample acceptance: a sample is accepted on any rising edge with sample_valid=1; there is no backpressure, so every valid sample is accepted. Cycles with sample_valid=0 change no sample state.
- Stage 1 (edge of acceptance, cycle T):
  - Per channel, delta_i = |cur_i - prev_i| computed in DATA_W+1 bits signed, magnitude in DATA_W+1 bits unsigned; no wrap.
  - prev_i <= cur_i.
  - d_valid <= 1 unless FSM=PRIME.
- Stage 2 (cycle T+1, when d_valid=1):
  - Per-channel level = 3 if delta > LVL3, else 2 if > LVL2, else 1 if > LVL1, else 0. Comparisons are strict.
  - lvl_max = maximum level over channels; mask bit i = (level_i != 0).
- Output (edge ending cycle T+1): if d_valid and lvl_max != 0 and FSM=ARMED:
  - beat_en=1 for exactly one cycle (observed in cycle T+2).
  - beat_intensity <= lvl_max; beat_ch <= mask.
  - Otherwise beat_en=0 and beat_intensity/beat_ch hold.
- Latency: accepted sample to beat_en is 2 cycles. Back-to-back valid samples are supported at full rate.
- FSM states:
  - PRIME: first accepted sample only primes prev; go to ARMED. No beat can result from the priming sample.
  - ARMED: on a beat emission, if HOLDOFF_CYC>0, go to HOLDOFF with counter <= HOLDOFF_CYC-1 and holdoff <= 1; if HOLDOFF_CYC=0, stay ARMED.
  - HOLDOFF: counter decrements each cycle. At counter=0, go to ARMED and holdoff <= 0. Samples are still accepted and prev still updates; qualifying deltas are discarded, not queued.
- Boundaries:
  - Qualifying delta arriving in the same cycle the counter hits 0 is suppressed; the first eligible delta is the one evaluated in the following cycle.
  - Delta exactly equal to a threshold grades to the lower level.
  - Full-scale swing (min to max) = 2^DATA_W - 1; no overflow.
  - Reset mid-hold-off or mid-pipeline aborts everything and returns to PRIME.
  - NUM_CH=1 is legal.

Optional Feature:
BEAT_DETECTOR_COUNT_EN
- Defined: adds output port beat_count (16 bits), reset to 0, incremented on every beat_en pulse, saturating at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Prime: reset, one sample {0,0,0} then {7000,0,0} on consecutive cycles -> beat_en pulse 2 cycles after second sample, intensity=3, beat_ch=3'b001; first sample gives no pulse.
- Signed and boundary grading: prev ch1=-2000, cur ch1=+2500 (delta 4500) -> intensity=1, beat_ch=3'b010. Next cur=+7001 (delta 4501) is inside hold-off; set HOLDOFF_CYC=0 for this check -> intensity=2.
- Max across channels: deltas {3500, 5000, 100} -> intensity=2, beat_ch=3'b011, single-cycle beat_en.
- Hold-off: HOLDOFF_CYC=8, beat, then qualifying samples every cycle:
  - holdoff=1 for 8 cycles and no beat_en.
  - First beat after holdoff falls occurs for the delta evaluated the cycle after counter=0.
- Reset mid-hold-off: assert rst in hold-off cycle 3 -> all outputs 0 immediately. After release, the first sample does not beat (PRIME); the second qualifying sample beats.
- Idle gaps: sample_valid toggled 1,0,0,1 with delta 6600 between the two valid samples -> one beat, intensity=3; zero-valid cycles produce no beat and no prev update. With BEAT_DETECTOR_COUNT_EN, beat_count increments by 1.
